// File: rtl/versat_databus_arbiter.sv
// versat_databus_arbiter
// Shares one external-memory databus master port among NUM_REQ Versat unit
// databus ports. Round-robin arbitration at burst granularity; the winner is
// locked until its final beat and its request is forwarded combinationally.
//
// Ports:
//   clk, rst          clock, asynchronous active-low reset
//   s_valid/s_addr/s_wdata/s_wstrb/s_len   per-requester requests (slice i = requester i)
//   s_ready/s_last    per-requester beat accept / last beat (granted requester only)
//   s_rdata           read data, broadcast to all requesters
//   m_valid/m_addr/m_wdata/m_wstrb/m_len   master request to the AXI bridge
//   m_ready/m_rdata/m_last                 master beat accept, read data, last beat
//   grant             one-hot current owner (0 when idle)
//   busy              high while a burst is locked
//
// Build option: define VERSAT_DATABUS_ARB_FIXED_PRIO_EN to replace round-robin
// with fixed priority (lowest index wins).
module versat_databus_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned AXI_ADDR_W = 64
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             s_valid,
    input  logic [NUM_REQ*AXI_ADDR_W-1:0]  s_addr,
    input  logic [NUM_REQ*DATA_W-1:0]      s_wdata,
    input  logic [NUM_REQ*(DATA_W/8)-1:0]  s_wstrb,
    input  logic [NUM_REQ*8-1:0]           s_len,
    output logic [NUM_REQ-1:0]             s_ready,
    output logic [DATA_W-1:0]              s_rdata,
    output logic [NUM_REQ-1:0]             s_last,
    output logic                           m_valid,
    output logic [AXI_ADDR_W-1:0]          m_addr,
    output logic [DATA_W-1:0]              m_wdata,
    output logic [DATA_W/8-1:0]            m_wstrb,
    output logic [7:0]                     m_len,
    input  logic                           m_ready,
    input  logic [DATA_W-1:0]              m_rdata,
    input  logic                           m_last,
    output logic [NUM_REQ-1:0]             grant,
    output logic                           busy
);

    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned LEN_W  = 8;

    typedef enum logic {IDLE, LOCK} state_t;

    state_t             state;
    logic [IDX_W-1:0]   owner;
    logic               win_found;
    logic [IDX_W-1:0]   win_idx;
`ifndef VERSAT_DATABUS_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]   last_owner;
    int unsigned        cand;
`endif

    // Per-requester views of the flattened request buses
    logic [AXI_ADDR_W-1:0] addr_a  [NUM_REQ];
    logic [DATA_W-1:0]     wdata_a [NUM_REQ];
    logic [STRB_W-1:0]     wstrb_a [NUM_REQ];
    logic [LEN_W-1:0]      len_a   [NUM_REQ];

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_split
        assign addr_a[i]  = s_addr[i*AXI_ADDR_W +: AXI_ADDR_W];
        assign wdata_a[i] = s_wdata[i*DATA_W +: DATA_W];
        assign wstrb_a[i] = s_wstrb[i*STRB_W +: STRB_W];
        assign len_a[i]   = s_len[i*LEN_W +: LEN_W];
    end

    // Winner selection for the next burst
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
`ifdef VERSAT_DATABUS_ARB_FIXED_PRIO_EN
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!win_found && s_valid[IDX_W'(k)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(k);
            end
        end
`else
        cand = 0;
        // Scan upward starting just after the previous owner
        for (int unsigned k = 1; k <= NUM_REQ; k++) begin
            cand = (32'(last_owner) + k) % NUM_REQ;
            if (!win_found && s_valid[IDX_W'(cand)]) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
`endif
    end

    // Arbitration FSM: grant on entry to LOCK, release on the last handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            owner      <= '0;
            grant      <= '0;
`ifndef VERSAT_DATABUS_ARB_FIXED_PRIO_EN
            last_owner <= IDX_W'(NUM_REQ - 1);
`endif
        end else if (state == IDLE) begin
            if (win_found) begin
                state <= LOCK;
                owner <= win_idx;
                grant <= NUM_REQ'(1) << win_idx;
            end
        end else begin
            if (m_valid && m_ready && m_last) begin
                state      <= IDLE;
                grant      <= '0;
`ifndef VERSAT_DATABUS_ARB_FIXED_PRIO_EN
                last_owner <= owner;
`endif
            end
        end
    end

    // Combinational forwarding of the locked requester; all zero when idle
    always_comb begin
        m_valid = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_wstrb = '0;
        m_len   = '0;
        s_ready = '0;
        s_last  = '0;
        if (state == LOCK) begin
            m_valid = s_valid[owner];
            m_addr  = addr_a[owner];
            m_wdata = wdata_a[owner];
            m_wstrb = wstrb_a[owner];
            m_len   = len_a[owner];
            s_ready = grant & {NUM_REQ{m_ready}};
            s_last  = grant & {NUM_REQ{m_last}};
        end
    end

    assign s_rdata = m_rdata;
    assign busy    = (state == LOCK);

endmodule

// File: tb/tb_versat_databus_arbiter.sv
module tb_versat_databus_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned AW = 64;
    localparam int unsigned SW = DW / 8;
    localparam logic [DW-1:0] RDATA = 32'hA5A5_0F0F;

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [NR-1:0]   s_valid = '0;
    logic [NR*AW-1:0] s_addr = '0;
    logic [NR*DW-1:0] s_wdata = '0;
    logic [NR*SW-1:0] s_wstrb = '0;
    logic [NR*8-1:0] s_len = '0;
    logic [NR-1:0]   s_ready;
    logic [DW-1:0]   s_rdata;
    logic [NR-1:0]   s_last;
    logic            m_valid;
    logic [AW-1:0]   m_addr;
    logic [DW-1:0]   m_wdata;
    logic [SW-1:0]   m_wstrb;
    logic [7:0]      m_len;
    logic            m_ready = 1'b1;
    logic [DW-1:0]   m_rdata = RDATA;
    logic            m_last;
    logic [NR-1:0]   grant;
    logic            busy;

    versat_databus_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .AXI_ADDR_W(AW)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_len(s_len),
        .s_ready(s_ready), .s_rdata(s_rdata), .s_last(s_last),
        .m_valid(m_valid), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_len(m_len),
        .m_ready(m_ready), .m_rdata(m_rdata), .m_last(m_last),
        .grant(grant), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory side: signals last on beat m_len+1 of each burst
    logic [7:0] beat_cnt;
    always @(posedge clk or negedge rst) begin
        if (!rst) beat_cnt <= 8'd0;
        else if (m_valid && m_ready) beat_cnt <= m_last ? 8'd0 : beat_cnt + 8'd1;
    end
    assign m_last = m_valid && (beat_cnt == m_len);

    typedef struct {
        int            cyc;
        logic [NR-1:0] grant;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
        logic [7:0]    len;
        logic          last;
    } beat_t;

    beat_t exp_q[$];
    beat_t mon_e;
    int vectors = 0;
    int miscompares = 0;

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Monitor: pops one expected beat per master handshake
    always @(negedge clk) begin
        if (rst) begin
            check("grant_onehot0", 128'($onehot0(grant)), 128'(1));
            check("busy_vs_grant", 128'(busy), 128'(|grant));
            if (!busy)
                check("idle_outputs", {m_valid, s_ready, s_last, m_addr, m_wdata, m_wstrb, m_len}, 128'(0));
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_beat: got grant %0h, expected no beat (cycle %0d)", grant, cyc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("beat_cycle", 128'(cyc), 128'(mon_e.cyc));
                    check("grant", 128'(grant), 128'(mon_e.grant));
                    check("m_addr", 128'(m_addr), 128'(mon_e.addr));
                    check("m_wdata", 128'(m_wdata), 128'(mon_e.wdata));
                    check("m_wstrb", 128'(m_wstrb), 128'(mon_e.wstrb));
                    check("m_len", 128'(m_len), 128'(mon_e.len));
                    check("s_ready", 128'(s_ready), 128'(mon_e.grant));
                    check("s_last", 128'(s_last), 128'(mon_e.last ? mon_e.grant : '0));
                    check("s_rdata", 128'(s_rdata), 128'(RDATA));
                end
            end
        end
    end

    // Requester driver state
    int cnt[NR];
    int start[NR];

    task automatic apply();
        for (int i = 0; i < NR; i++) s_valid[i] = (cnt[i] > 0) && (cyc >= start[i]);
    endtask

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < NR; i++)
            if (s_valid[i] && s_ready[i] && s_last[i]) cnt[i]--;
        @(posedge clk);
        #1;
        apply();
    endtask

    task automatic set_req(input int i, input int n, input int off, input logic [AW-1:0] a,
                           input logic [DW-1:0] wd, input logic [SW-1:0] ws, input logic [7:0] l);
        cnt[i]   = n;
        start[i] = cyc + off;
        s_addr[i*AW +: AW]  = a;
        s_wdata[i*DW +: DW] = wd;
        s_wstrb[i*SW +: SW] = ws;
        s_len[i*8 +: 8]     = l;
    endtask

    task automatic push(input int c, input int g, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                        input logic [SW-1:0] ws, input logic [7:0] l, input logic last);
        beat_t b;
        b.cyc = c; b.grant = NR'(1) << g; b.addr = a; b.wdata = wd;
        b.wstrb = ws; b.len = l; b.last = last;
        exp_q.push_back(b);
    endtask

    function automatic bit pending();
        for (int i = 0; i < NR; i++) if (cnt[i] > 0) return 1'b1;
        return 1'b0;
    endfunction

    task automatic run(input int budget);
        int n = 0;
        while ((busy || pending() || exp_q.size() > 0) && n < budget) begin
            step();
            n++;
        end
        if (n >= budget) begin
            vectors++;
            miscompares++;
            $display("FAIL run_timeout: got %0d cycles, expected under %0d", n, budget);
        end
    endtask

    int c0;

    initial begin
        for (int i = 0; i < NR; i++) begin cnt[i] = 0; start[i] = 0; end
        #1;
        check("rst_grant", 128'(grant), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_m_bus", {m_valid, m_addr, m_wdata, m_wstrb, m_len}, 128'(0));
        check("rst_s_ready_last", 128'({s_ready, s_last}), 128'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        step();

        // All four request, len 0; requester 0 wants two bursts
        c0 = cyc;
        for (int i = 0; i < NR; i++)
            set_req(i, (i == 0) ? 2 : 1, 0, 64'h100 * (i + 1), 32'h0, 4'h0, 8'd0);
        apply();
`ifdef VERSAT_DATABUS_ARB_FIXED_PRIO_EN
        push(c0 + 1, 0, 64'h100, 0, 0, 0, 1);
        push(c0 + 3, 0, 64'h100, 0, 0, 0, 1);
        push(c0 + 5, 1, 64'h200, 0, 0, 0, 1);
        push(c0 + 7, 2, 64'h300, 0, 0, 0, 1);
        push(c0 + 9, 3, 64'h400, 0, 0, 0, 1);
`else
        push(c0 + 1, 0, 64'h100, 0, 0, 0, 1);
        push(c0 + 3, 1, 64'h200, 0, 0, 0, 1);
        push(c0 + 5, 2, 64'h300, 0, 0, 0, 1);
        push(c0 + 7, 3, 64'h400, 0, 0, 0, 1);
        push(c0 + 9, 0, 64'h100, 0, 0, 0, 1);
`endif
        run(60);

        // Single requester 2, four-beat read burst
        c0 = cyc;
        set_req(2, 1, 0, 64'h2000, 32'h0, 4'h0, 8'd3);
        apply();
        for (int b = 0; b < 4; b++) push(c0 + 1 + b, 2, 64'h2000, 0, 0, 3, b == 3);
        run(40);
        check("release_cycle", 128'(cyc), 128'(c0 + 5));
        check("release_grant", 128'(grant), 128'(0));

        // Write forwarding from requester 3
        c0 = cyc;
        set_req(3, 1, 0, 64'h1000, 32'hDEADBEEF, 4'hF, 8'd1);
        apply();
        push(c0 + 1, 3, 64'h1000, 32'hDEADBEEF, 4'hF, 1, 0);
        push(c0 + 2, 3, 64'h1000, 32'hDEADBEEF, 4'hF, 1, 1);
        run(40);

        // Requester 0 arrives mid-burst of requester 1: no pre-emption
        c0 = cyc;
        set_req(1, 1, 0, 64'h3000, 32'h0, 4'h0, 8'd3);
        set_req(0, 1, 2, 64'h4000, 32'h0, 4'h0, 8'd0);
        apply();
        for (int b = 0; b < 4; b++) push(c0 + 1 + b, 1, 64'h3000, 0, 0, 3, b == 3);
        push(c0 + 6, 0, 64'h4000, 0, 0, 0, 1);
        run(40);

        // Reset during beat 2 of a 5-beat burst
        c0 = cyc;
        set_req(1, 1, 0, 64'h5000, 32'h0, 4'h0, 8'd4);
        apply();
        push(c0 + 1, 1, 64'h5000, 0, 0, 4, 0);
        step();
        step();
        #2;
        rst = 1'b0;
        #1;
        check("midrst_grant_busy", 128'({grant, busy}), 128'(0));
        check("midrst_m_bus", {m_valid, m_addr, m_wdata, m_wstrb, m_len}, 128'(0));
        check("midrst_s_ready_last", 128'({s_ready, s_last}), 128'(0));
        for (int i = 0; i < NR; i++) cnt[i] = 0;
        apply();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        step();

        // Fresh arbitration after reset starts at requester 0
        c0 = cyc;
        set_req(0, 1, 0, 64'h6000, 32'h0, 4'h0, 8'd0);
        set_req(2, 1, 0, 64'h7000, 32'h0, 4'h0, 8'd0);
        apply();
        push(c0 + 1, 0, 64'h6000, 0, 0, 0, 1);
        push(c0 + 3, 2, 64'h7000, 0, 0, 0, 1);
        run(40);

        check("queue_drained", 128'(exp_q.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
